piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with a bit-valid strobe.
- It is the transmit end for the team's serial-in shift-register receivers.
- Built from synchronously reset flip-flops, for flip-flop/shift-register test benches and small serial links.

Parameters:
- WIDTH, 8, bits per word (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- data  input  WIDTH  parallel word to send.
- load_valid  input  1  data is valid.
- load_ready  output  1  block can accept a word this cycle.
- q  output  1  serial data out.
- q_valid  output  1  q carries a frame bit this cycle.
- first  output  1  high during the first data bit of a frame.
- last  output  1  high during the final bit of a frame (the parity bit when parity is enabled).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, named reset. It is sampled only on the clk rising edge.
- Reset (reset==0 at an edge):
  - State goes to IDLE; shift register, bit counter and parity accumulator are cleared.
  - q=0, q_valid=0, first=0, last=0, load_ready=1 after that edge.
- Handshake:
  - A transfer occurs at an edge where load_valid && load_ready.
  - While load_ready=0, load_valid is ignored and no data is captured; the sender holds its word.
  - load_valid has no combinational path to any output.
- States: IDLE, SHIFT, PARITY (PARITY only when PARITY_EN is defined).
- IDLE: load_ready=1, q_valid=0, q=0. A transfer moves the state to SHIFT, loads the shift register with data and sets the counter to 0.
- SHIFT:
  - q_valid=1 and q = current output bit (MSB or LSB of the shift register, per MSB_FIRST).
  - first=1 when counter==0.
  - Each edge shifts the register by one and increments the counter.
  - When counter==WIDTH-1 (the last data bit):
    - Without PARITY_EN: last=1 and load_ready=1.
    - With PARITY_EN: next state is PARITY.
- Latency: bit k of the frame (k=0..WIDTH-1) appears on q in the (k+1)th cycle after the accepting edge. One word takes exactly WIDTH cycles (WIDTH+1 with parity).
- Back-to-back: a transfer accepted during the last-bit cycle starts the next frame's first bit in the immediately following cycle, with no idle gap. Without such a transfer, the state returns to IDLE and q is driven to 0.
- Counter: width $clog2(WIDTH); it wraps only via reload, never by overflow.
- Reset mid-frame: the frame is aborted and the remaining bits are never sent. Reset has priority over a simultaneous transfer.
- first and last are never both high, since WIDTH≥2.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, one extra PARITY cycle drives q = even parity (XOR of the word), with q_valid=1, last=1, load_ready=1.
  - Back-to-back acceptance is allowed in the PARITY cycle.
  - In SHIFT, last stays 0.
- Undefined: the PARITY state, its logic and the parity accumulator are absent; frames are WIDTH bits.

Decomposition:
- Package piso_pkg:
  - state enum type (IDLE, SHIFT, PARITY);
  - localparam helper for counter width;
  - reset-active constant RESET_ACTIVE=1'b0.
- Sub-module piso_bit_counter: a synchronously reset, active-low, loadable up-counter with a terminal-count flag (count==WIDTH-1). The top instantiates it once.

Test Plan (WIDTH=8):
- Reset: hold reset=0 for 2 edges with load_valid=1 and data=8'hFF → q=0, q_valid=0, load_ready=1; no frame starts after reset is released until a new transfer.
- MSB_FIRST=1, data=8'hA5, single load → cycles 1–8 give q=1,0,1,0,0,1,0,1; first in cycle 1; last in cycle 8; then IDLE with q=0.
- MSB_FIRST=0, data=8'h01 → q=1 then seven 0s.
- Back-to-back: load 8'hF0, keep load_valid=1 with data=8'h0F → q_valid stays 1 for 16 consecutive cycles carrying 11110000 then 00001111; load_ready=1 only in cycles 8 and 16.
- Busy/mid-frame reset: assert load_valid during cycle 3 of a frame → ignored, and the frame completes unchanged. Then assert reset=0 during cycle 4 of the next frame → after the edge q_valid=0, q=0, load_ready=1, and the remaining bits are never sent.
- PISO_PARITY_EN defined, data=8'hA7 → 9 valid cycles; the 9th has q=1 (five ones) with last=1. With data=8'hA5 the 9th bit is 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_shift_tx serial transmitter.
package piso_pkg;

  localparam logic RESET_ACTIVE = 1'b0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY
  } state_e;

  // Bit-counter width; a 2-bit word still needs one counter bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// Loadable up-counter with terminal-count flag at WIDTH-1; synchronous active-low reset.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load and bit strobes.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             first,
  output logic             last
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]    cnt;
  logic             cnt_tc, cnt_load, cnt_inc;
  logic             out_bit;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign out_bit  = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
  assign sr_shift = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

  piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .count (cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    load_ready = 1'b0;
    q          = 1'b0;
    q_valid    = 1'b0;
    first      = 1'b0;
    last       = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: load_ready = 1'b1;
      S_SHIFT: begin
        q_valid = 1'b1;
        q       = out_bit;
        first   = (cnt == '0);
        sr_d    = sr_shift;
`ifdef PISO_PARITY_EN
        parity_d = parity_q ^ out_bit;
`endif
        // Hold the counter at WIDTH-1 so it only ever restarts via reload.
        if (!cnt_tc) begin
          cnt_inc = 1'b1;
        end else begin
`ifdef PISO_PARITY_EN
          state_d = S_PARITY;
`else
          last       = 1'b1;
          load_ready = 1'b1;
          state_d    = S_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        q_valid    = 1'b1;
        q          = parity_q;
        last       = 1'b1;
        load_ready = 1'b1;
        state_d    = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A transfer in the final cycle of a frame starts the next one with no gap.
    if (load_ready && load_valid) begin
      state_d  = S_SHIFT;
      sr_d     = data;
      cnt_load = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: frame-queue model plus directed literal checks.
module tb_piso_shift_tx;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] data;
  logic         rdy_m, q_m, qv_m, f_m, l_m;
  logic         rdy_l, q_l, qv_l, f_l, l_l;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] bits_m, bits_l, rdys, firsts, lasts;
  int          nv;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .data(data), .load_valid(load_valid),
    .load_ready(rdy_m), .q(q_m), .q_valid(qv_m), .first(f_m), .last(l_m)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .data(data), .load_valid(load_valid),
    .load_ready(rdy_l), .q(q_l), .q_valid(qv_l), .first(f_l), .last(l_l)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted word becomes a queue of {first,last,q} entries, one per output cycle.
  typedef logic [2:0] ent_t;
  ent_t mq_m[$];
  ent_t mq_l[$];

  function automatic ent_t ent(input logic [W-1:0] d, input int k, input bit msb);
    if (k == W) return {1'b0, 1'b1, ^d};
    return {(k == 0), (FL == W) && (k == W - 1), msb ? d[W-1-k] : d[k]};
  endfunction

  always @(posedge clk) begin : model
    bit rdy;
    rdy = (mq_m.size() <= 1);
    if (reset === 1'b0) begin
      mq_m.delete();
      mq_l.delete();
    end else begin
      if (mq_m.size() > 0) void'(mq_m.pop_front());
      if (mq_l.size() > 0) void'(mq_l.pop_front());
      if (load_valid === 1'b1 && rdy) begin
        for (int k = 0; k < FL; k++) begin
          mq_m.push_back(ent(data, k, 1'b1));
          mq_l.push_back(ent(data, k, 1'b0));
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0] em, el;
    if (chk_en) begin
      em = (mq_m.size() > 0) ? {1'b1, mq_m[0], mq_m.size() == 1} : 5'b00001;
      el = (mq_l.size() > 0) ? {1'b1, mq_l[0], mq_l.size() == 1} : 5'b00001;
      cmp("model_msb", {27'd0, qv_m, f_m, l_m, q_m, rdy_m}, {27'd0, em});
      cmp("model_lsb", {27'd0, qv_l, f_l, l_l, q_l, rdy_l}, {27'd0, el});
    end
  end

  task automatic clr();
    bits_m = '0; bits_l = '0; rdys = '0; firsts = '0; lasts = '0; nv = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    bits_m = {bits_m[30:0], q_m};
    bits_l = {bits_l[30:0], q_l};
    rdys   = {rdys[30:0], rdy_m};
    firsts = {firsts[30:0], f_m};
    lasts  = {lasts[30:0], l_m};
    if (qv_m === 1'b1) nv++;
  endtask

  task automatic send(input logic [W-1:0] d);
    @(posedge clk);
    #1 data = d; load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  logic [31:0] exp_b2b;

  initial begin
    reset = 1'b0; load_valid = 1'b1; data = 8'hFF;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    cmp("rst_q", {31'd0, q_m}, 32'd0);
    cmp("rst_qv", {31'd0, qv_m}, 32'd0);
    cmp("rst_rdy", {31'd0, rdy_m}, 32'd1);
    reset = 1'b1; load_valid = 1'b0;
    clr(); repeat (4) sample();
    cmp("post_rst_idle", nv, 0);

    // Single MSB-first / LSB-first frame of A5.
    send(8'hA5);
    clr(); repeat (FL) sample();
    cmp("a5_msb", bits_m >> (FL - W), 32'hA5);
    cmp("a5_lsb", bits_l >> (FL - W), 32'hA5);
    cmp("a5_first", firsts, 32'd1 << (FL - 1));
    cmp("a5_last", lasts, 32'd1);
    cmp("a5_nvalid", nv, FL);
    clr(); repeat (2) sample();
    cmp("a5_idle_after", {bits_m[1:0], 30'd0} | nv, 32'd0);

    // 01: LSB-first sends 1 then seven 0s.
    send(8'h01);
    clr(); repeat (FL) sample();
    cmp("x01_lsb", bits_l >> (FL - W), 32'h80);
    cmp("x01_msb", bits_m >> (FL - W), 32'h01);

    // Back-to-back F0 then 0F, load_valid held through the handover.
    @(posedge clk);
    #1 data = 8'hF0; load_valid = 1'b1;
    @(posedge clk);
    #1 data = 8'h0F;
    clr();
    for (int i = 0; i < 2 * FL; i++) begin
      sample();
      if (i == FL) load_valid = 1'b0;
    end
`ifdef PISO_PARITY_EN
    exp_b2b = {14'd0, 8'hF0, 1'b0, 8'h0F, 1'b0};
`else
    exp_b2b = {16'd0, 8'hF0, 8'h0F};
`endif
    cmp("b2b_bits", bits_m, exp_b2b);
    cmp("b2b_nvalid", nv, 2 * FL);
    cmp("b2b_ready", rdys, (32'd1 << FL) | 32'd1);

    // Load attempt while busy is ignored.
    send(8'h3C);
    clr();
    for (int i = 0; i < FL; i++) begin
      sample();
      if (i == 2) begin load_valid = 1'b1; data = 8'hFF; end
      if (i == 3) load_valid = 1'b0;
    end
    cmp("busy_bits", bits_m >> (FL - W), 32'h3C);
    clr(); repeat (3) sample();
    cmp("busy_no_capture", nv, 0);

    // Reset in cycle 4 of a frame aborts it.
    send(8'hC3);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp("midrst_qv", {31'd0, qv_m}, 32'd0);
    cmp("midrst_q", {31'd0, q_m}, 32'd0);
    cmp("midrst_rdy", {31'd0, rdy_m}, 32'd1);
    reset = 1'b1;
    clr(); repeat (FL) sample();
    cmp("midrst_no_tail", nv, 0);

`ifdef PISO_PARITY_EN
    send(8'hA7);
    clr(); repeat (FL) sample();
    cmp("par_a7", bits_m, {23'd0, 8'hA7, 1'b1});
    cmp("par_a7_last", lasts, 32'd1);
    send(8'hA5);
    clr(); repeat (FL) sample();
    cmp("par_a5", bits_m, {23'd0, 8'hA5, 1'b0});
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
